// File: rtl/ssd_word_scanner.sv
// Multiplexed seven-segment scanner with double-buffered digit words,
// frame-synchronous commit, PWM brightness and per-digit blink.
module ssd_word_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 200000,
  parameter int BLINK_FRAMES = 125,
  localparam int IDXW        = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [IDXW-1:0]       wr_idx,
  input  logic [6:0]            wr_seg,
  input  logic                  commit,
  output logic                  commit_ack,
  input  logic [NUM_DIGITS-1:0] blink_mask,
  input  logic [2:0]            brightness,
  output logic [6:0]            cathodes,
  output logic [NUM_DIGITS-1:0] anodes,
  output logic                  frame_tick
);

  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDXW-1:0]  DIG_MAX = IDXW'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_FRAMES - 1);

  // Number of prescaler counts per slot during which the digit is driven.
  function automatic logic [31:0] on_limit(input logic [2:0] b);
    return ((32'(b) + 32'd1) * 32'(SCAN_DIV)) >> 3;
  endfunction

  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [IDXW-1:0]       dig_q, dig_d;
  logic [BLK_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic                  pending_q, pending_d;
  logic [6:0]            shadow_q [NUM_DIGITS];
  logic [6:0]            shadow_d [NUM_DIGITS];
  logic [6:0]            active_q [NUM_DIGITS];
  logic [6:0]            active_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] anodes_q, anodes_d;
  logic [6:0]            cathodes_q, cathodes_d;
  logic                  ack_q, ack_d;
  logic                  tick_q, tick_d;

  logic slot_tick, frame_wrap, do_copy, blank;

  always_comb begin
    slot_tick     = (pre_q == PRE_MAX);
    frame_wrap    = slot_tick && (dig_q == DIG_MAX);
    do_copy       = frame_wrap && (pending_q || commit);

    pre_d         = slot_tick ? '0 : pre_q + PRE_W'(1);
    dig_d         = dig_q;
    if (slot_tick) dig_d = (dig_q == DIG_MAX) ? '0 : dig_q + IDXW'(1);

    pending_d     = pending_q;
    if (do_copy)     pending_d = 1'b0;
    else if (commit) pending_d = 1'b1;

    // Active takes the registered shadow, so a same-cycle write lands only in shadow.
    active_d      = active_q;
    if (do_copy) active_d = shadow_q;
    shadow_d      = shadow_q;
    if (wr_en && (32'(wr_idx) < NUM_DIGITS)) shadow_d[wr_idx] = wr_seg;

    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_wrap) begin
      if (blink_cnt_q == BLK_MAX) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d   = blink_cnt_q + BLK_W'(1);
      end
    end

    blank = (32'(pre_q) >= on_limit(brightness)) ||
            (blink_phase_q && blink_mask[dig_q]);
    anodes_d   = '1;
    cathodes_d = 7'h7F;
    if (!blank) begin
      anodes_d[dig_q] = 1'b0;
      cathodes_d      = ~active_q[dig_q];
    end

    ack_d  = do_copy;
    tick_d = frame_wrap;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q         <= '0;
      dig_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      pending_q     <= 1'b0;
      shadow_q      <= '{default: '0};
      active_q      <= '{default: '0};
      anodes_q      <= '1;
      cathodes_q    <= 7'h7F;
      ack_q         <= 1'b0;
      tick_q        <= 1'b0;
    end else begin
      pre_q         <= pre_d;
      dig_q         <= dig_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      pending_q     <= pending_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      anodes_q      <= anodes_d;
      cathodes_q    <= cathodes_d;
      ack_q         <= ack_d;
      tick_q        <= tick_d;
    end
  end

  assign anodes     = anodes_q;
  assign cathodes   = cathodes_q;
  assign commit_ack = ack_q;
  assign frame_tick = tick_q;

endmodule

// File: doc/ssd_word_scanner.md
SSD_WORD_SCANNER -- requirements
Module: ssd_word_scanner

Interface
REQ-001 The block SHALL have these parameters, one per line:
- NUM_DIGITS, default 4, number of multiplexed digits (2..8).
- SCAN_DIV, default 200000, clk cycles per digit slot (at least 8).
- BLINK_FRAMES, default 125, full frames per blink half-period (at least 1).
REQ-002 IDXW SHALL be clog2(NUM_DIGITS).
REQ-003 The block SHALL have these ports, one per line:
- clk  in  1  rising-edge clock; sole clock.
- rst_n  in  1  reset; synchronous, active-low.
- wr_en  in  1  write one shadow digit this cycle.
- wr_idx  in  IDXW  shadow digit index; index 0 is the rightmost digit.
- wr_seg  in  7  segment pattern, active-high, bit6=a through bit0=g.
- commit  in  1  single-cycle request to copy shadow to active at the next frame boundary.
- commit_ack  out  1  single-cycle pulse in the cycle the copy occurs.
- blink_mask  in  NUM_DIGITS  per-digit blink enable.
- brightness  in  3  on-time within each slot, in eighths minus one (0 = 1/8, 7 = full).
- cathodes  out  7  active-low segments, bit6=a through bit0=g.
- anodes  out  NUM_DIGITS  active-low digit enables, at most one low.
- frame_tick  out  1  single-cycle pulse when a frame ends.

Function
REQ-004 Prescaler pre SHALL count 0..SCAN_DIV-1, then wrap to 0; a slot tick is pre==SCAN_DIV-1.
REQ-005 Digit index dig SHALL advance by 1 on each slot tick and wrap from NUM_DIGITS-1 to 0.
REQ-006 A frame wrap is a slot tick with dig==NUM_DIGITS-1; frame_tick SHALL be 1 in the cycle after the frame wrap.
REQ-007 Two buffers SHALL exist, shadow and active, each holding NUM_DIGITS 7-bit patterns.
REQ-008 Writes SHALL touch only shadow; a write with wr_idx>=NUM_DIGITS SHALL be ignored.
REQ-009 commit SHALL set a pending flag; further commits while pending SHALL be absorbed (one ack).
REQ-010 On a frame wrap with pending set, or with commit high in that same cycle, active SHALL load all of shadow, pending SHALL clear, and commit_ack SHALL pulse in the next cycle.
REQ-011 A write in the same cycle as the copy SHALL update shadow only; active SHALL receive the pre-write shadow contents.
REQ-012 Blink counter SHALL count frame wraps 0..BLINK_FRAMES-1; on wrap it SHALL toggle blink_phase.
REQ-013 The current digit SHALL be blanked when pre >= ((brightness+1)*SCAN_DIV)/8 (integer divide), or when blink_phase==1 and blink_mask[dig]==1.
REQ-014 When the digit is not blanked: anodes = all ones with bit dig cleared, and cathodes = ~active[dig].
REQ-015 When the digit is blanked: anodes = all ones and cathodes = 7'b1111111.
REQ-016 cathodes and anodes SHALL be registered and reflect the dig and pre values of the previous cycle (one-cycle latency).
REQ-017 blink_mask and brightness SHALL be sampled every cycle; a change takes effect on the next output register update.

Reset
REQ-018 While rst_n==0 at a clk edge, the following SHALL be set:
- pre=0, dig=0, blink counter=0, blink_phase=0, pending=0.
- shadow and active all zero.
- anodes all ones, cathodes=7'b1111111.
- commit_ack=0, frame_tick=0.
REQ-019 Reset asserted mid-frame or with pending set SHALL discard the pending commit with no ack.
REQ-020 After release, the first slot tick SHALL occur SCAN_DIV cycles after the first cycle with rst_n==1.

Verification (NUM_DIGITS=4, SCAN_DIV=8, BLINK_FRAMES=2)
REQ-021 Scan order: write 7'h77,7'h4F,7'h5B,7'h67 to idx0..3, then commit, brightness=7.
- First frame wrap -> commit_ack pulses once.
- Following frame -> anodes cycle 1110,1101,1011,0111, 8 cycles each; cathodes 0001000,0110000,0100100,0011000.
REQ-022 Tearing: write idx2=7'h7E mid-frame without commit -> cathodes on digit 2 unchanged. Then commit -> change appears only from the slot after the next frame_tick.
REQ-023 Brightness: brightness=1 -> anode low for exactly 2 of every 8 cycles per slot. brightness=0 -> 1 of 8.
REQ-024 Blink: blink_mask=4'b0001 -> digit 0 lit frames 0-1, blank frames 2-3, lit frames 4-5; other digits always lit.
REQ-025 Edge events:
- commit asserted in the frame-wrap cycle -> ack in the next cycle.
- commit 3x in one frame -> single ack.
- wr_idx=3 with NUM_DIGITS=3 -> no change.
- rst_n low with pending set -> outputs off, no ack after release.
